// File: rtl/cpuc_bus_arbiter_if.sv
// Bus-request interface for cpuc_bus_arbiter: request vector in, one-hot driver enables out.
interface cpuc_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned IdW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [IdW-1:0]         owner_id;
  logic                   bus_busy;
  logic                   preempt;

  // Requester side.
  modport master (
    output req,
    input  grant,
    input  owner_id,
    input  bus_busy,
    input  preempt
  );

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output owner_id,
    output bus_busy,
    output preempt
  );
endinterface

// File: rtl/cpuc_bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus: one-hot grant, bounded hold time,
// and a mandatory one-cycle dead TURN slot between any two owners.
module cpuc_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cpuc_bus_arbiter_if.slave    bus
);

  localparam int unsigned IdW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdW-1:0]         owner_q, owner_d;
  logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   preempt_q, preempt_d;

  logic                   win_found;
  logic [IdW-1:0]         win_idx;
  logic [IdW-1:0]         cand_idx;
  logic                   owner_req;
  logic                   others_req;
  logic                   hold_at_max;

  // Search starts at rr_ptr, so the most recent owner is ranked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand_idx = IdW'((32'(rr_ptr_q) + i) % NUM_MASTERS);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign owner_req   = bus.req[owner_q];
  assign others_req  = |(bus.req & ~grant_q);
  assign hold_at_max = (hold_cnt_q == HoldW'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      StIdle, StTurn: begin
        if (win_found) begin
          state_d    = StGrant;
          grant_d    = NUM_MASTERS'(1) << win_idx;
          owner_d    = win_idx;
          rr_ptr_d   = IdW'((32'(win_idx) + 1) % NUM_MASTERS);
          hold_cnt_d = HoldW'(1);
        end else begin
          state_d    = StIdle;
          grant_d    = '0;
          owner_d    = '0;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!owner_req || (hold_at_max && others_req)) begin
          state_d    = StTurn;
          grant_d    = '0;
          owner_d    = '0;
          hold_cnt_d = '0;
          // Owner still wanting the bus here means it was cut off by the hold limit.
          preempt_d  = owner_req;
        end else if (!hold_at_max) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        owner_d    = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner_id = owner_q;
  assign bus.bus_busy = |grant_q;
  assign bus.preempt  = preempt_q;

endmodule

// File: tb/tb_cpuc_bus_arbiter.sv
// Directed-vector bench for cpuc_bus_arbiter with NUM_MASTERS=4, MAX_HOLD=4.
module tb_cpuc_bus_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  cpuc_bus_arbiter_if #(.NUM_MASTERS(4)) bus_if ();

  cpuc_bus_arbiter #(
    .NUM_MASTERS(4),
    .MAX_HOLD   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_bus(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic p);
    check_eq({tag, ".grant"},    32'(bus_if.grant),    32'(g));
    check_eq({tag, ".owner_id"}, 32'(bus_if.owner_id), 32'(o));
    check_eq({tag, ".bus_busy"}, 32'(bus_if.bus_busy), 32'(g != 4'b0000));
    check_eq({tag, ".preempt"},  32'(bus_if.preempt),  32'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants: never multi-hot, bus_busy tracks grant.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("onehot0", 32'($onehot0(bus_if.grant)), 32'd1);
      check_eq("busy_mirror", 32'(bus_if.bus_busy), 32'(|bus_if.grant));
    end
  end

  initial begin
    logic [1:0] rr_seq [5];
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.req = 4'b0000;
    #2;
    expect_bus("reset_no_clk", 4'b0000, 2'd0, 1'b0);
    tick();
    tick();
    expect_bus("reset_clk", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // Single requester, 3 sampled cycles
    bus_if.req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_bus("single", 4'b0010, 2'd1, 1'b0);
    end
    bus_if.req = 4'b0000;
    tick();
    expect_bus("single_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("single_idle", 4'b0000, 2'd0, 1'b0);

    // One-cycle request (rr_ptr=2, so search wraps to 0)
    bus_if.req = 4'b0001;
    tick();
    expect_bus("glitch", 4'b0001, 2'd0, 1'b0);
    bus_if.req = 4'b0000;
    tick();
    expect_bus("glitch_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("glitch_idle", 4'b0000, 2'd0, 1'b0);

    // Round robin with preemption from rr_ptr=0
    rst = 1'b1;
    #1;
    expect_bus("rst_pulse", 4'b0000, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expect_bus("rr_grant", 4'b0001 << rr_seq[k], rr_seq[k], 1'b0);
      end
      if (k < 4) begin
        tick();
        expect_bus("rr_turn", 4'b0000, 2'd0, 1'b1);
      end
    end
    bus_if.req = 4'b0000;
    tick();
    expect_bus("rr_release", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("rr_idle", 4'b0000, 2'd0, 1'b0);

    // Sole owner past MAX_HOLD keeps the bus (rr_ptr=1)
    bus_if.req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      expect_bus("sole", 4'b0100, 2'd2, 1'b0);
    end
    bus_if.req = 4'b0000;
    tick();
    expect_bus("sole_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("sole_idle", 4'b0000, 2'd0, 1'b0);

    // Handover 0 -> 3 through one TURN cycle (rr_ptr=3)
    bus_if.req = 4'b0001;
    tick();
    expect_bus("ho_own0", 4'b0001, 2'd0, 1'b0);
    bus_if.req = 4'b1001;
    tick();
    expect_bus("ho_own0_hold", 4'b0001, 2'd0, 1'b0);
    bus_if.req = 4'b1000;
    tick();
    expect_bus("ho_turn", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("ho_own3", 4'b1000, 2'd3, 1'b0);
    bus_if.req = 4'b0000;
    tick();
    expect_bus("ho_turn2", 4'b0000, 2'd0, 1'b0);
    tick();
    bus_if.req = 4'b1111;
    tick();
    expect_bus("ho_rrptr0", 4'b0001, 2'd0, 1'b0);

    // Reset during grant of master 2 (rr_ptr=1 after draining)
    bus_if.req = 4'b0000;
    tick();
    tick();
    bus_if.req = 4'b0100;
    tick();
    expect_bus("mid_pre", 4'b0100, 2'd2, 1'b0);
    rst = 1'b1;
    #1;
    expect_bus("mid_async", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_bus("mid_held", 4'b0000, 2'd0, 1'b0);
    bus_if.req = 4'b0110;
    rst = 1'b0;
    tick();
    expect_bus("mid_restart", 4'b0010, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
